// File: rtl/timer_pkg.sv
// Shared stopwatch types: BCD count width and lap stage states.
// Used by lap_hold and lap_store.
package timer_pkg;

    localparam int BCD_DIGITS = 6;
    localparam int COUNT_W    = 4 * BCD_DIGITS;

    typedef enum logic [1:0] {
        LIVE   = 2'd0,
        FREEZE = 2'd1,
        RECALL = 2'd2
    } lap_state_t;

endpackage

// File: rtl/lap_store.sv
// Lap buffer: DEPTH x COUNT_W words, one sync write, one comb read.
// Ports: clk, we/waddr/wdata (write), raddr -> rdata (read). No reset.
module lap_store
    import timer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [COUNT_W-1:0] wdata,
    input  logic [AW-1:0]      raddr,
    output logic [COUNT_W-1:0] rdata
);

    logic [COUNT_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/lap_hold.sv
// Lap/split capture between BCD counter and segment decoders.
// Ports: clk, rst (sync, active-low), count_in, lap/recall/clear
// pulses -> disp, lap_cnt, rd_idx, overflow, blank.
// LAP_BLINK_EN: when defined, blank toggles every BLINK_CYCLES in
// RECALL; otherwise blank is tied to 0 and no blink counter exists.
module lap_hold
    import timer_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int HOLD_CYCLES  = 100_000_000,
    parameter int BLINK_CYCLES = 12_500_000,
    localparam int CW          = $clog2(DEPTH + 1),
    localparam int AW          = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [COUNT_W-1:0] count_in,
    input  logic               lap_pulse,
    input  logic               recall_pulse,
    input  logic               clear_pulse,
    output logic [COUNT_W-1:0] disp,
    output logic [CW-1:0]      lap_cnt,
    output logic [AW-1:0]      rd_idx,
    output logic               overflow,
    output logic               blank
);

    localparam int TW = $clog2(HOLD_CYCLES);

    lap_state_t         state_q, state_d;
    logic [COUNT_W-1:0] disp_q, disp_d;
    logic [CW-1:0]      lap_cnt_q, lap_cnt_d;
    logic [AW-1:0]      rd_idx_q, rd_idx_d;
    logic               ovf_q, ovf_d;
    logic [TW-1:0]      timer_q, timer_d;

    logic               we;
    logic [AW-1:0]      raddr;
    logic [COUNT_W-1:0] rdata;
    logic               full;
    logic               last;

    lap_store #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_store (
        .clk   (clk),
        .we    (we),
        .waddr (lap_cnt_q[AW-1:0]),
        .wdata (count_in),
        .raddr (raddr),
        .rdata (rdata)
    );

    assign full = (lap_cnt_q == CW'(DEPTH));
    assign last = (CW'(rd_idx_q) == lap_cnt_q - CW'(1));

    // Single read port: slot 0 when entering RECALL, next slot
    // when stepping inside RECALL.
    assign raddr = (state_q == RECALL) ? rd_idx_q + AW'(1) : '0;

    always_comb begin
        state_d   = state_q;
        disp_d    = disp_q;
        lap_cnt_d = lap_cnt_q;
        rd_idx_d  = rd_idx_q;
        ovf_d     = ovf_q;
        timer_d   = timer_q;
        we        = 1'b0;

        if (clear_pulse) begin
            lap_cnt_d = '0;
            ovf_d     = 1'b0;
            rd_idx_d  = '0;
            timer_d   = '0;
            state_d   = LIVE;
            disp_d    = count_in;
        end else if (lap_pulse) begin
            if (!full) begin
                we        = 1'b1;
                lap_cnt_d = lap_cnt_q + CW'(1);
            end else begin
                ovf_d = 1'b1;
            end
            // In RECALL the lap is stored silently.
            if (state_q != RECALL) begin
                disp_d  = count_in;
                timer_d = TW'(HOLD_CYCLES - 1);
                state_d = FREEZE;
            end
        end else if (recall_pulse && state_q == RECALL) begin
            if (last) begin
                state_d = LIVE;
                disp_d  = count_in;
            end else begin
                rd_idx_d = rd_idx_q + AW'(1);
                disp_d   = rdata;
            end
        end else if (recall_pulse && lap_cnt_q != '0) begin
            state_d  = RECALL;
            rd_idx_d = '0;
            timer_d  = '0;
            disp_d   = rdata;
        end else begin
            case (state_q)
                LIVE: begin
                    disp_d = count_in;
                end
                FREEZE: begin
                    if (timer_q == '0) begin
                        state_d = LIVE;
                        disp_d  = count_in;
                    end else begin
                        timer_d = timer_q - TW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= LIVE;
            disp_q    <= '0;
            lap_cnt_q <= '0;
            rd_idx_q  <= '0;
            ovf_q     <= 1'b0;
            timer_q   <= '0;
        end else begin
            state_q   <= state_d;
            disp_q    <= disp_d;
            lap_cnt_q <= lap_cnt_d;
            rd_idx_q  <= rd_idx_d;
            ovf_q     <= ovf_d;
            timer_q   <= timer_d;
        end
    end

`ifdef LAP_BLINK_EN
    localparam int BW = $clog2(BLINK_CYCLES + 1);

    logic          blank_q, blank_d;
    logic [BW-1:0] blink_q, blink_d;

    // Blink runs only while staying in RECALL; entry and exit
    // restart it from a visible (unblanked) phase.
    always_comb begin
        blank_d = 1'b0;
        blink_d = '0;
        if (state_q == RECALL && state_d == RECALL) begin
            if (blink_q == BW'(BLINK_CYCLES - 1)) begin
                blank_d = ~blank_q;
                blink_d = '0;
            end else begin
                blank_d = blank_q;
                blink_d = blink_q + BW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            blank_q <= 1'b0;
            blink_q <= '0;
        end else begin
            blank_q <= blank_d;
            blink_q <= blink_d;
        end
    end

    assign blank = blank_q;
`else
    logic [31:0] unused_blink;
    assign unused_blink = 32'(BLINK_CYCLES);
    assign blank        = 1'b0;
`endif

    assign disp     = disp_q;
    assign lap_cnt  = lap_cnt_q;
    assign rd_idx   = rd_idx_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_lap_hold.sv
// Scoreboard bench for lap_hold (DEPTH=4, HOLD=8, BLINK=3).
// Expectations queued at drive time, popped after each edge.
module tb_lap_hold;
    import timer_pkg::*;

    localparam int DEPTH = 4;
    localparam int HOLD  = 8;
    localparam int BLINK = 3;
`ifdef LAP_BLINK_EN
    localparam bit BLINK_ON = 1'b1;
`else
    localparam bit BLINK_ON = 1'b0;
`endif

    localparam logic [4:0] ALL = 5'h1f;
    localparam logic [4:0] NI  = 5'h1b;

    logic        clk;
    logic        rst;
    logic [23:0] count_in;
    logic        lap_pulse;
    logic        recall_pulse;
    logic        clear_pulse;
    logic [23:0] disp;
    logic [2:0]  lap_cnt;
    logic [1:0]  rd_idx;
    logic        overflow;
    logic        blank;

    lap_hold #(
        .DEPTH        (DEPTH),
        .HOLD_CYCLES  (HOLD),
        .BLINK_CYCLES (BLINK)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .count_in     (count_in),
        .lap_pulse    (lap_pulse),
        .recall_pulse (recall_pulse),
        .clear_pulse  (clear_pulse),
        .disp         (disp),
        .lap_cnt      (lap_cnt),
        .rd_idx       (rd_idx),
        .overflow     (overflow),
        .blank        (blank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [4:0]  m;
        logic [23:0] d;
        logic [2:0]  c;
        logic [1:0]  i;
        logic        o;
        logic        b;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        #2;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            if (e.m[0]) check({e.tag, ".disp"}, 32'(disp), 32'(e.d));
            if (e.m[1]) check({e.tag, ".cnt"}, 32'(lap_cnt), 32'(e.c));
            if (e.m[2]) check({e.tag, ".idx"}, 32'(rd_idx), 32'(e.i));
            if (e.m[3]) check({e.tag, ".ovf"}, 32'(overflow), 32'(e.o));
            if (e.m[4]) check({e.tag, ".blank"}, 32'(blank), 32'(e.b));
        end
    end

    task automatic cyc(input logic l, input logic r, input logic c,
                       input logic [23:0] ci, input string tag,
                       input logic [4:0] m, input logic [23:0] ed,
                       input logic [2:0] ec, input logic [1:0] ei,
                       input logic eo, input logic eb);
        exp_t e;
        lap_pulse    = l;
        recall_pulse = r;
        clear_pulse  = c;
        count_in     = ci;
        e.tag = tag;
        e.m   = m;
        e.d   = ed;
        e.c   = ec;
        e.i   = ei;
        e.o   = eo;
        e.b   = eb & BLINK_ON;
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        cyc(1, 1, 0, 24'h999999, "rst", ALL, 24'h0, 0, 0, 0, 0);
        cyc(1, 1, 0, 24'h999998, "rst", ALL, 24'h0, 0, 0, 0, 0);
        rst = 1'b1;

        cyc(0, 0, 0, 24'h000123, "live", ALL, 24'h000123, 0, 0, 0, 0);

        cyc(1, 0, 0, 24'h001545, "lap", NI, 24'h001545, 1, 0, 0, 0);
        for (int k = 1; k < HOLD; k++)
            cyc(0, 0, 0, 24'h002000 + 24'(k), "frz", NI,
                24'h001545, 1, 0, 0, 0);
        cyc(0, 0, 0, 24'h003000, "resume", NI, 24'h003000, 1, 0, 0, 0);
        cyc(0, 0, 0, 24'h003001, "track", NI, 24'h003001, 1, 0, 0, 0);

        cyc(0, 0, 1, 24'h004000, "clr", NI, 24'h004000, 0, 0, 0, 0);
        cyc(1, 0, 0, 24'h000100, "l1", NI, 24'h000100, 1, 0, 0, 0);
        cyc(1, 0, 0, 24'h000200, "l2", NI, 24'h000200, 2, 0, 0, 0);
        cyc(1, 0, 0, 24'h000300, "l3", NI, 24'h000300, 3, 0, 0, 0);
        cyc(0, 1, 0, 24'h555555, "rc0", ALL, 24'h000100, 3, 0, 0, 0);
        cyc(0, 0, 0, 24'h555556, "rc0h", ALL, 24'h000100, 3, 0, 0, 0);
        cyc(0, 1, 0, 24'h555557, "rc1", ALL, 24'h000200, 3, 1, 0, 0);
        cyc(0, 1, 0, 24'h555558, "rc2", ALL, 24'h000300, 3, 2, 0, 1);
        cyc(0, 1, 0, 24'h006000, "rcx", NI, 24'h006000, 3, 0, 0, 0);

        cyc(0, 1, 0, 24'h007000, "br0", ALL, 24'h000100, 3, 0, 0, 0);
        cyc(1, 0, 0, 24'h000400, "blap", ALL, 24'h000100, 4, 0, 0, 0);
        for (int k = 2; k <= 6; k++)
            cyc(0, 0, 0, 24'h007100 + 24'(k), "blk", ALL,
                24'h000100, 4, 0, 0, (k >= 3 && k <= 5));
        cyc(0, 1, 0, 24'h007200, "br1", ALL, 24'h000200, 4, 1, 0, 0);
        cyc(0, 1, 0, 24'h007201, "br2", ALL, 24'h000300, 4, 2, 0, 0);
        cyc(0, 1, 0, 24'h007202, "br3", ALL, 24'h000400, 4, 3, 0, 1);
        cyc(0, 1, 0, 24'h008000, "brx", NI, 24'h008000, 4, 0, 0, 0);

        cyc(0, 0, 1, 24'h008100, "clr2", NI, 24'h008100, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++)
            cyc(1, 0, 0, 24'(32'h010000 + k * 32'h100), "ovf", NI,
                24'(32'h010000 + k * 32'h100),
                (k < 4) ? 3'(k + 1) : 3'd4, 0, (k == 4), 0);
        cyc(0, 0, 0, 24'h011111, "ovfh", NI, 24'h010400, 4, 0, 1, 0);
        cyc(0, 0, 1, 24'h012000, "clr3", NI, 24'h012000, 0, 0, 0, 0);
        cyc(0, 0, 0, 24'h012001, "live3", NI, 24'h012001, 0, 0, 0, 0);

        cyc(1, 0, 0, 24'h000700, "l7", NI, 24'h000700, 1, 0, 0, 0);
        cyc(1, 1, 0, 24'h000800, "lr", NI, 24'h000800, 2, 0, 0, 0);
        cyc(0, 0, 0, 24'h000801, "lrh", NI, 24'h000800, 2, 0, 0, 0);
        cyc(0, 1, 0, 24'h000802, "lrrc", ALL, 24'h000700, 2, 0, 0, 0);
        cyc(1, 0, 1, 24'h000900, "cl", NI, 24'h000900, 0, 0, 0, 0);
        cyc(0, 0, 0, 24'h000901, "cll", NI, 24'h000901, 0, 0, 0, 0);
        cyc(0, 1, 0, 24'h000a00, "rce", NI, 24'h000a00, 0, 0, 0, 0);

        cyc(1, 0, 0, 24'h011111, "rl1", NI, 24'h011111, 1, 0, 0, 0);
        for (int k = 0; k < 3; k++)
            cyc(0, 0, 0, 24'h020000 + 24'(k), "rlh1", NI,
                24'h011111, 1, 0, 0, 0);
        cyc(1, 0, 0, 24'h022222, "rl2", NI, 24'h022222, 2, 0, 0, 0);
        for (int k = 1; k < HOLD; k++)
            cyc(0, 0, 0, 24'h021000 + 24'(k), "rlh2", NI,
                24'h022222, 2, 0, 0, 0);
        cyc(0, 0, 0, 24'h030000, "rlx", NI, 24'h030000, 2, 0, 0, 0);

        rst = 1'b0;
        cyc(1, 0, 0, 24'h044444, "rst2", ALL, 24'h0, 0, 0, 0, 0);
        rst = 1'b1;
        cyc(0, 0, 0, 24'h045000, "post", ALL, 24'h045000, 0, 0, 0, 0);

        lap_pulse    = 1'b0;
        recall_pulse = 1'b0;
        clear_pulse  = 1'b0;
        repeat (2) @(negedge clk);
        check("drain", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
